// File: rtl/dms_pkg.sv
// Shared definitions for the SAM2 configuration sequencer: frame constants,
// controller state encoding and the key-length helper.
package dms_pkg;

   localparam int N_W       = 4;   // width of the n field in the SAM2 frame
   localparam int KEY_W_DEF = 16;  // default maximum key length in bits

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RST_CORE = 3'd1,
      LOAD_N   = 3'd2,
      LOAD_D   = 3'd3,
      LOAD_C   = 3'd4,
      RUN      = 3'd5
   } state_t;

   // Key length L = 2**n
   function automatic int unsigned key_len(input logic [N_W-1:0] n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/dms_piso.sv
// Parallel-in serial-out shifter, MSB first. A load places the lowest len+1
// bits of din at the top of the register so the field MSB is presented on
// dout immediately; last is high while dout carries the final bit of the field.
module dms_piso #(
   parameter int W     = 16,
   parameter int LEN_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [W-1:0]     din,
   input  logic [LEN_W-1:0] len,
   output logic             dout,
   output logic             last
);

   logic [W-1:0]     shreg_r;
   logic [LEN_W-1:0] cnt_r;
   logic [LEN_W-1:0] shamt_s;

   assign shamt_s = LEN_W'(W - 1) - len;
   assign dout    = shreg_r[W-1];
   assign last    = (cnt_r == LEN_W'(0));

   // Load a left-justified field or shift one bit out; the counter saturates at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_r <= '0;
         cnt_r   <= '0;
      end else if (load) begin
         shreg_r <= din << shamt_s;
         cnt_r   <= len;
      end else if (shift) begin
         shreg_r <= {shreg_r[W-2:0], 1'b0};
         if (cnt_r != LEN_W'(0)) begin
            cnt_r <= cnt_r - LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/dms_cfg_sequencer.sv
// Front-end controller for the SAM2 decryption core. Validates and latches a
// key configuration, resets the core, serialises n/d/capsN onto str with
// mode=1, then switches the core to run mode and forwards the retimed line.
module dms_cfg_sequencer
   import dms_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [N_W-1:0]   cfg_n,
   input  logic [KEY_W-1:0] cfg_d,
   input  logic [KEY_W-1:0] cfg_caps,
   output logic             cfg_done,
   output logic             cfg_err,
   input  logic             line_in,
   output logic             core_str,
   output logic             core_mode,
   output logic             core_reset_n,
   output logic             busy
);

   localparam int CNT_W = $clog2(KEY_W) + 1;

   state_t           state_r, state_s;
   logic [N_W-1:0]   n_r;
   logic [KEY_W-1:0] d_r, caps_r;
   logic             field_done_r;  // the last bit of the current field went out on the previous edge
   logic             accept_s, ok_s, start_s, emit_s;
   logic             load_s, shift_s;
   logic [KEY_W-1:0] din_s;
   logic [CNT_W-1:0] len_s, len_key_s;
   logic             piso_dout_s, piso_last_s;
   logic             str_s, mode_s, rstn_s, busy_s, ready_s, done_s, err_s;
   logic             core_str_r, core_mode_r, core_reset_n_r, busy_r;
   logic             cfg_ready_r, cfg_done_r, cfg_err_r;

   assign accept_s  = cfg_valid & cfg_ready_r;
   assign ok_s      = (key_len(cfg_n) <= unsigned'(KEY_W));
   assign len_key_s = CNT_W'(key_len(n_r) - 32'd1);

   // Next state plus shifter control; the state names the field on core_str after the edge
   always_comb begin
      state_s = state_r;
      start_s = 1'b0;
      load_s  = 1'b0;
      shift_s = 1'b0;
      din_s   = '0;
      len_s   = '0;
      case (state_r)
         IDLE, RUN: begin
            if (accept_s && ok_s) begin
               state_s = RST_CORE;
               start_s = 1'b1;
               load_s  = 1'b1;
               din_s   = KEY_W'(cfg_n);
               len_s   = CNT_W'(N_W - 1);
            end else begin
               state_s = state_r;
            end
         end
         RST_CORE: state_s = LOAD_N;
         LOAD_N:   state_s = field_done_r ? LOAD_D : LOAD_N;
         LOAD_D:   state_s = field_done_r ? LOAD_C : LOAD_D;
         LOAD_C:   state_s = field_done_r ? RUN : LOAD_C;
         default:  state_s = IDLE;
      endcase
      emit_s = (state_s == LOAD_N) || (state_s == LOAD_D) || (state_s == LOAD_C);
      if (emit_s && piso_last_s && (state_s == LOAD_N)) begin
         load_s = 1'b1;
         din_s  = d_r;
         len_s  = len_key_s;
      end else if (emit_s && piso_last_s && (state_s == LOAD_D)) begin
         load_s = 1'b1;
         din_s  = caps_r;
         len_s  = len_key_s;
      end else if (emit_s) begin
         shift_s = 1'b1;
      end else begin
         shift_s = 1'b0;
      end
   end

   // Output values for the state entered on the coming edge
   always_comb begin
      str_s   = 1'b0;
      mode_s  = 1'b0;
      rstn_s  = 1'b0;
      busy_s  = 1'b0;
      ready_s = 1'b0;
      case (state_s)
         IDLE:     ready_s = 1'b1;
         RST_CORE: busy_s  = 1'b1;
         LOAD_N, LOAD_D, LOAD_C: begin
            str_s  = piso_dout_s;
            mode_s = 1'b1;
            rstn_s = 1'b1;
            busy_s = 1'b1;
         end
         RUN: begin
            str_s   = line_in;
            rstn_s  = 1'b1;
            ready_s = 1'b1;
         end
         default: ready_s = 1'b0;
      endcase
      done_s = (state_s == RUN) && (state_r != RUN);
      err_s  = accept_s && !ok_s;
   end

   // State register and end-of-field flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         field_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         field_done_r <= emit_s & piso_last_s;
      end
   end

   // Latch the validated configuration on acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_r    <= '0;
         d_r    <= '0;
         caps_r <= '0;
      end else if (start_s) begin
         n_r    <= cfg_n;
         d_r    <= cfg_d;
         caps_r <= cfg_caps;
      end
   end

   // Registered outputs; in RUN the str flop doubles as the line retiming stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_str_r     <= 1'b0;
         core_mode_r    <= 1'b0;
         core_reset_n_r <= 1'b0;
         busy_r         <= 1'b0;
         cfg_ready_r    <= 1'b0;
         cfg_done_r     <= 1'b0;
         cfg_err_r      <= 1'b0;
      end else begin
         core_str_r     <= str_s;
         core_mode_r    <= mode_s;
         core_reset_n_r <= rstn_s;
         busy_r         <= busy_s;
         cfg_ready_r    <= ready_s;
         cfg_done_r     <= done_s;
         cfg_err_r      <= err_s;
      end
   end

   dms_piso #(
      .W     (KEY_W),
      .LEN_W (CNT_W)
   ) u_piso (
      .clk   (clk),
      .reset (reset),
      .load  (load_s),
      .shift (shift_s),
      .din   (din_s),
      .len   (len_s),
      .dout  (piso_dout_s),
      .last  (piso_last_s)
   );

   assign core_str     = core_str_r;
   assign core_mode    = core_mode_r;
   assign core_reset_n = core_reset_n_r;
   assign busy         = busy_r;
   assign cfg_ready    = cfg_ready_r;
   assign cfg_done     = cfg_done_r;
   assign cfg_err      = cfg_err_r;

endmodule

// File: tb/tb_dms_cfg_sequencer.sv
// Scoreboard bench for dms_cfg_sequencer: the driver pushes the expected serial
// frame and error events when a request is accepted, and a negedge monitor pops
// and compares while also checking control outputs against a cycle-level model.
module tb_dms_cfg_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [3:0]  cfg_n = 4'd0;
   logic [15:0] cfg_d = 16'd0;
   logic [15:0] cfg_caps = 16'd0;
   logic        cfg_done, cfg_err;
   logic        line_in = 1'b0;
   logic        core_str, core_mode, core_reset_n, busy;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   int   exp_e = -1;   // edge at which the current config was accepted, -1 when idle
   int   exp_r = 0;    // edge at which RUN starts for that config
   logic prev_line = 1'b0;
   logic exp_bits[$];
   int   exp_err[$];
   logic line_q[$];

   dms_cfg_sequencer #(.KEY_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_n        (cfg_n),
      .cfg_d        (cfg_d),
      .cfg_caps     (cfg_caps),
      .cfg_done     (cfg_done),
      .cfg_err      (cfg_err),
      .line_in      (line_in),
      .core_str     (core_str),
      .core_mode    (core_mode),
      .core_reset_n (core_reset_n),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) prev_line <= line_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare every cycle against the model, popping frame bits while mode=1
   always @(negedge clk) begin : mon
      logic em, ern, eb, erdy, ed;
      logic bit_exp;
      int   err_exp;
      if (mon_en) begin
         if (exp_e < 0) begin
            em = 1'b0; ern = 1'b0; eb = 1'b0; erdy = 1'b1; ed = 1'b0;
         end else if (cyc == exp_e) begin
            em = 1'b0; ern = 1'b0; eb = 1'b1; erdy = 1'b0; ed = 1'b0;
         end else if (cyc < exp_r) begin
            em = 1'b1; ern = 1'b1; eb = 1'b1; erdy = 1'b0; ed = 1'b0;
         end else begin
            em = 1'b0; ern = 1'b1; eb = 1'b0; erdy = 1'b1; ed = (cyc == exp_r);
         end
         check("mode", core_mode, em);
         check("core_reset_n", core_reset_n, ern);
         check("busy", busy, eb);
         check("cfg_ready", cfg_ready, erdy);
         check("cfg_done", cfg_done, ed);
         if (core_mode === 1'b1) begin
            if (exp_bits.size() == 0) begin
               check("frame_extra_bit", 32'(exp_bits.size()), 1);
            end else begin
               bit_exp = exp_bits.pop_front();
               check("frame_bit", core_str, bit_exp);
            end
         end else if (exp_e >= 0 && cyc >= exp_r) begin
            check("run_passthrough", core_str, prev_line);
         end else begin
            check("str_quiet", core_str, 0);
         end
         if (cfg_err === 1'b1) begin
            if (exp_err.size() == 0) begin
               check("err_unexpected", 32'(exp_err.size()), 1);
            end else begin
               err_exp = exp_err.pop_front();
               check("err_cycle", cyc, err_exp);
            end
         end else if (exp_err.size() > 0 && exp_err[0] < cyc) begin
            err_exp = exp_err.pop_front();
            check("err_missing", cyc, err_exp);
         end
      end
   end

   // Line stimulus: queued pattern first, random otherwise
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (line_q.size() > 0) line_in = line_q.pop_front();
         else line_in = 1'($urandom_range(0, 1));
      end
   end

   task automatic apply_reset(input int cycles);
      mon_en = 1'b0;
      reset  = 1'b1;
      #1;
      check("rst_str", core_str, 0);
      check("rst_mode", core_mode, 0);
      check("rst_core_reset_n", core_reset_n, 0);
      check("rst_ready", cfg_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", cfg_done, 0);
      check("rst_err", cfg_err, 0);
      exp_bits.delete();
      exp_err.delete();
      exp_e = -1;
      exp_r = 0;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", cfg_ready, 1);
      mon_en = 1'b1;
   endtask

   task automatic send(input logic [3:0] n, input logic [15:0] d, input logic [15:0] c,
                       input bit hold);
      int guard = 0;
      int acc, len;
      @(posedge clk);
      #1;
      while (cfg_ready !== 1'b1 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) begin
         check("ready_timeout", guard, 0);
      end else begin
         cfg_valid = 1'b1;
         cfg_n = n;
         cfg_d = d;
         cfg_caps = c;
         @(posedge clk);
         #1;
         acc = cyc;
         if ((1 << n) <= 16) begin
            len = 1 << n;
            exp_e = acc;
            exp_r = acc + 5 + 2 * len;
            for (int i = 3; i >= 0; i--) exp_bits.push_back(n[i]);
            for (int i = len - 1; i >= 0; i--) exp_bits.push_back(d[i]);
            for (int i = len - 1; i >= 0; i--) exp_bits.push_back(c[i]);
            if (hold) begin
               for (int k = 0; k < 2 * len + 3; k++) begin
                  cfg_n = 4'($urandom_range(0, 4));
                  cfg_d = 16'($urandom);
                  cfg_caps = 16'($urandom);
                  @(posedge clk);
                  #1;
               end
            end
         end else begin
            exp_err.push_back(acc);
         end
         cfg_valid = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] rn;
      repeat (2) @(posedge clk);
      #1;
      apply_reset(2);

      // Worked frame: 0010 | 1010 | 0011, RUN 13 edges after accept
      send(4'd2, 16'h000A, 16'h0003, 1'b0);
      repeat (16) @(posedge clk);

      // Passthrough pattern in RUN
      line_q.push_back(1'b0); line_q.push_back(1'b0); line_q.push_back(1'b1);
      line_q.push_back(1'b1); line_q.push_back(1'b1);
      repeat (8) @(posedge clk);

      // Reconfigure from RUN with the shortest key
      send(4'd0, 16'h0001, 16'h0000, 1'b0);
      repeat (10) @(posedge clk);

      // Rejected request in RUN keeps RUN
      send(4'd5, 16'h1234, 16'h5678, 1'b0);
      repeat (4) @(posedge clk);

      // Rejected request in IDLE keeps the core in reset
      #1;
      apply_reset(1);
      send(4'd7, 16'hFFFF, 16'hFFFF, 1'b0);
      repeat (4) @(posedge clk);

      // Valid held through a load with changing data
      send(4'd3, 16'($urandom), 16'($urandom), 1'b1);
      repeat (12) @(posedge clk);

      // Reset in the middle of LOAD_D
      send(4'd4, 16'hBEEF, 16'hCAFE, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      apply_reset(2);

      // Random configurations, including rejects and reconfiguration mid-RUN
      for (int it = 0; it < 40; it++) begin
         rn = 4'($urandom_range(0, 6));
         send(rn, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 30)) @(posedge clk);
      end

      repeat (45) @(posedge clk);
      #1;
      check("frame_bits_left", 32'(exp_bits.size()), 0);
      check("err_events_left", 32'(exp_err.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
